// File: rtl/bus_arbiter.sv
// ----------------------------------------------------------------------------
// bus_arbiter
//
// Round-robin arbiter that shares one slave port of the simple wait-state bus
// between NUM_MASTERS masters. Each arbitration grants exactly one transfer:
// one IDLE cycle picks the next requester, and the GRANT state then passes
// the master's request through to the slave until the slave drops wait.
// A wait-state timeout forces an error completion on a hung slave.
//
// Ports (master i occupies slice i of every master-indexed vector):
//   clk, rst          clock, asynchronous active-high reset
//   m_bus_ena         per-master transfer request
//   m_bus_wstb        per-master write strobes (all zero = read)
//   m_bus_addr        per-master address
//   m_bus_wdata       per-master write data
//   m_bus_wait        per-master stall (1 for every non-granted master)
//   m_bus_rdata       shared read data, valid for the completing master
//   m_bus_slverr      per-master error response
//   s_bus_*           single slave port (ena/wstb/addr/wdata out,
//                     wait/rdata/slverr in)
//   grant_valid       high while a master holds the grant
//   grant_id          index of the granted master (registered)
//   timeout_pulse     one-cycle pulse on a forced (timed-out) completion
// ----------------------------------------------------------------------------
module bus_arbiter #(
   parameter int NUM_MASTERS = 4,
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int TIMEOUT     = 256,
   localparam int IW         = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1,
   localparam int STB_W      = DATA_WIDTH / 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_MASTERS-1:0]            m_bus_ena,
   input  logic [NUM_MASTERS*STB_W-1:0]      m_bus_wstb,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_bus_addr,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_bus_wdata,
   output logic [NUM_MASTERS-1:0]            m_bus_wait,
   output logic [DATA_WIDTH-1:0]             m_bus_rdata,
   output logic [NUM_MASTERS-1:0]            m_bus_slverr,
   output logic                              s_bus_ena,
   output logic [STB_W-1:0]                  s_bus_wstb,
   output logic [ADDR_WIDTH-1:0]             s_bus_addr,
   output logic [DATA_WIDTH-1:0]             s_bus_wdata,
   input  logic                              s_bus_wait,
   input  logic [DATA_WIDTH-1:0]             s_bus_rdata,
   input  logic                              s_bus_slverr,
   output logic                              grant_valid,
   output logic [IW-1:0]                     grant_id,
   output logic                              timeout_pulse
);

   // With TIMEOUT=0 the counter is kept at one bit; it is never compared.
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   grant_q, grant_d;
   logic [IW-1:0]   last_q, last_d;
   logic [CW-1:0]   wait_cnt_q, wait_cnt_d;

   logic [IW-1:0]   pick;
   logic            pick_found;
   logic            req_g;
   logic            timeout_hit;

   assign req_g = m_bus_ena[grant_q];

   // A granted master that withdraws its request is treated as aborting, so
   // the timeout only fires while the request is still present.
   assign timeout_hit = (TIMEOUT > 0) && (state_q == ST_GRANT) && req_g &&
                        s_bus_wait && (wait_cnt_q == CW'(TIMEOUT));

   // Round-robin search: first requester at or after last_grant+1.
   always_comb begin
      pick       = '0;
      pick_found = 1'b0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         if (!pick_found && m_bus_ena[(int'(last_q) + k) % NUM_MASTERS]) begin
            pick_found = 1'b1;
            pick       = IW'((int'(last_q) + k) % NUM_MASTERS);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      last_d     = last_q;
      wait_cnt_d = wait_cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               state_d    = ST_GRANT;
               grant_d    = pick;
               wait_cnt_d = '0;
            end
         end
         ST_GRANT: begin
            if (!req_g) begin
               // Request dropped mid-transfer: abandon without advancing the
               // round-robin pointer.
               state_d = ST_IDLE;
            end else if (timeout_hit || !s_bus_wait) begin
               last_d  = grant_q;
               state_d = ST_IDLE;
            end else if (wait_cnt_q != '1) begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         last_q     <= IW'(NUM_MASTERS - 1);
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Datapath mux. Everything is derived from the registered state, so an
   // asynchronous reset drops the slave request and stalls all masters
   // without waiting for a clock edge.
   always_comb begin
      s_bus_ena    = 1'b0;
      s_bus_wstb   = '0;
      s_bus_addr   = '0;
      s_bus_wdata  = '0;
      m_bus_wait   = '1;
      m_bus_slverr = '0;
      m_bus_rdata  = '0;
      if (state_q == ST_GRANT) begin
         s_bus_ena             = req_g;
         s_bus_wstb            = m_bus_wstb[int'(grant_q)*STB_W +: STB_W];
         s_bus_addr            = m_bus_addr[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
         s_bus_wdata           = m_bus_wdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
         m_bus_wait[grant_q]   = timeout_hit ? 1'b0 : s_bus_wait;
         m_bus_slverr[grant_q] = timeout_hit ? 1'b1 : s_bus_slverr;
         m_bus_rdata           = timeout_hit ? '0 : s_bus_rdata;
      end
   end

   assign grant_valid   = (state_q == ST_GRANT);
   assign grant_id      = grant_q;
   assign timeout_pulse = timeout_hit;

endmodule

// File: tb/tb_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Bench for bus_arbiter (4 masters, TIMEOUT=4). A transaction-level reference
// model predicts every output each cycle; directed sequences cover the main
// scenarios, followed by a randomized phase of protocol-obeying masters and a
// randomly stalling slave.
// ----------------------------------------------------------------------------
module tb_bus_arbiter;
   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int TO = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    m_ena   = '0;
   logic [N*SW-1:0] m_wstb  = '0;
   logic [N*AW-1:0] m_addr  = '0;
   logic [N*DW-1:0] m_wdata = '0;
   logic [N-1:0]    m_wait;
   logic [DW-1:0]   m_rdata;
   logic [N-1:0]    m_slverr;
   logic            s_ena;
   logic [SW-1:0]   s_wstb;
   logic [AW-1:0]   s_addr;
   logic [DW-1:0]   s_wdata;
   logic            s_wait   = 1'b0;
   logic [DW-1:0]   s_rdata  = '0;
   logic            s_slverr = 1'b0;
   logic            gvalid;
   logic [1:0]      gid;
   logic            tpulse;

   always #5 clk = ~clk;

   bus_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .m_bus_ena(m_ena), .m_bus_wstb(m_wstb), .m_bus_addr(m_addr), .m_bus_wdata(m_wdata),
      .m_bus_wait(m_wait), .m_bus_rdata(m_rdata), .m_bus_slverr(m_slverr),
      .s_bus_ena(s_ena), .s_bus_wstb(s_wstb), .s_bus_addr(s_addr), .s_bus_wdata(s_wdata),
      .s_bus_wait(s_wait), .s_bus_rdata(s_rdata), .s_bus_slverr(s_slverr),
      .grant_valid(gvalid), .grant_id(gid), .timeout_pulse(tpulse)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   bit  md_busy;   // a transfer is currently granted
   int  md_g;      // granted master
   int  md_last;   // last master that completed
   int  md_waits;  // stalled cycles seen in the current transfer
   bit  done [N];

   logic            e_s_ena, e_gv, e_to;
   logic [SW-1:0]   e_s_wstb;
   logic [AW-1:0]   e_s_addr;
   logic [DW-1:0]   e_s_wdata, e_rdata;
   logic [N-1:0]    e_wait, e_slverr;
   logic [1:0]      e_gid;

   function automatic void model_reset();
      md_busy  = 0;
      md_g     = 0;
      md_last  = N - 1;
      md_waits = 0;
   endfunction

   function automatic void model_eval();
      bit to;
      e_s_ena = 0; e_s_wstb = '0; e_s_addr = '0; e_s_wdata = '0;
      e_wait = '1; e_slverr = '0; e_rdata = '0; e_to = 0;
      e_gv  = md_busy;
      e_gid = 2'(md_g);
      if (md_busy) begin
         to = m_ena[md_g] && s_wait && (md_waits == TO);
         e_s_ena        = m_ena[md_g];
         e_s_wstb       = m_wstb[md_g*SW +: SW];
         e_s_addr       = m_addr[md_g*AW +: AW];
         e_s_wdata      = m_wdata[md_g*DW +: DW];
         e_wait[md_g]   = to ? 1'b0 : s_wait;
         e_slverr[md_g] = to ? 1'b1 : s_slverr;
         e_rdata        = to ? '0 : s_rdata;
         e_to           = to;
      end
   endfunction

   function automatic void model_step();
      bit found;
      if (rst) begin
         model_reset();
      end else if (!md_busy) begin
         found = 0;
         for (int k = 1; k <= N; k++) begin
            if (!found && m_ena[(md_last + k) % N]) begin
               found    = 1;
               md_g     = (md_last + k) % N;
               md_busy  = 1;
               md_waits = 0;
            end
         end
      end else if (!m_ena[md_g]) begin
         md_busy = 0;
      end else if (!s_wait || md_waits == TO) begin
         md_last = md_g;
         md_busy = 0;
      end else begin
         md_waits++;
      end
   endfunction

   // ---------------- cycle helpers ----------------
   task automatic set_m(int i, bit ena, logic [SW-1:0] wstb, logic [AW-1:0] addr,
                        logic [DW-1:0] wdata);
      m_ena[i]            = ena;
      m_wstb[i*SW +: SW]  = wstb;
      m_addr[i*AW +: AW]  = addr;
      m_wdata[i*DW +: DW] = wdata;
   endtask

   task automatic set_s(bit w, logic [DW-1:0] rd, bit err);
      s_wait   = w;
      s_rdata  = rd;
      s_slverr = err;
   endtask

   // Called 1 time unit after a rising edge; samples 3 units later.
   task automatic settle();
      #3;
      model_eval();
      check_eq("s_ena",       64'(s_ena),    64'(e_s_ena));
      check_eq("s_wstb",      64'(s_wstb),   64'(e_s_wstb));
      check_eq("s_addr",      64'(s_addr),   64'(e_s_addr));
      check_eq("s_wdata",     64'(s_wdata),  64'(e_s_wdata));
      check_eq("m_wait",      64'(m_wait),   64'(e_wait));
      check_eq("m_rdata",     64'(m_rdata),  64'(e_rdata));
      check_eq("m_slverr",    64'(m_slverr), 64'(e_slverr));
      check_eq("grant_valid", 64'(gvalid),   64'(e_gv));
      check_eq("grant_id",    64'(gid),      64'(e_gid));
      check_eq("timeout",     64'(tpulse),   64'(e_to));
      for (int i = 0; i < N; i++) done[i] = m_ena[i] && !e_wait[i];
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   bit   stuck;
   int   seq [5] = '{0, 1, 2, 3, 0};

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      settle();
      check_eq("rst_s_ena",  64'(s_ena),  64'd0);
      check_eq("rst_m_wait", 64'(m_wait), 64'hF);
      check_eq("rst_gvalid", 64'(gvalid), 64'd0);
      check_eq("rst_gid",    64'(gid),    64'd0);
      check_eq("rst_rdata",  64'(m_rdata), 64'd0);
      check_eq("rst_tpulse", 64'(tpulse), 64'd0);
      rst = 1'b0;
      tick();

      // Master 2 read, zero-wait slave.
      set_m(2, 1, '0, 32'h100, '0);
      set_s(0, 32'hCAFEF00D, 0);
      settle();
      check_eq("t1_idle_s_ena", 64'(s_ena), 64'd0);
      tick();
      settle();
      check_eq("t1_s_ena",   64'(s_ena),    64'd1);
      check_eq("t1_s_addr",  64'(s_addr),   64'h100);
      check_eq("t1_m_wait",  64'(m_wait),   64'hB);
      check_eq("t1_rdata",   64'(m_rdata),  64'hCAFEF00D);
      check_eq("t1_slverr",  64'(m_slverr), 64'd0);
      check_eq("t1_gid",     64'(gid),      64'd2);
      tick();
      set_m(2, 0, '0, '0, '0);
      settle();
      tick();

      // Master 1 write with 3 slave wait states.
      set_m(1, 1, 4'hF, 32'h200, 32'h12345678);
      settle();
      tick();
      for (int k = 0; k < 4; k++) begin
         set_s(k < 3, 32'h0BAD0000 + 32'(k), 0);
         settle();
         check_eq("t3_wdata", 64'(s_wdata),   64'h12345678);
         check_eq("t3_wstb",  64'(s_wstb),    64'hF);
         check_eq("t3_wait1", 64'(m_wait[1]), 64'(k < 3));
         tick();
      end
      set_m(1, 0, '0, '0, '0);
      settle();
      tick();

      // Master 0 read against a hung slave: forced completion.
      set_m(0, 1, '0, 32'h300, '0);
      set_s(1, 32'hDEADBEEF, 0);
      settle();
      tick();
      for (int k = 1; k <= 5; k++) begin
         settle();
         check_eq("t4_wait0",  64'(m_wait[0]), 64'(k < 5));
         check_eq("t4_tpulse", 64'(tpulse),    64'(k == 5));
         if (k == 5) begin
            check_eq("t4_slverr", 64'(m_slverr), 64'h1);
            check_eq("t4_rdata",  64'(m_rdata),  64'd0);
         end
         tick();
      end
      set_m(0, 0, '0, '0, '0);
      settle();
      check_eq("t4_s_ena_after", 64'(s_ena),  64'd0);
      check_eq("t4_tpulse_after", 64'(tpulse), 64'd0);
      tick();

      // Slave error on master 3 read.
      set_m(3, 1, '0, 32'h400, '0);
      set_s(0, 32'h55AA, 1);
      settle();
      tick();
      settle();
      check_eq("t5_slverr", 64'(m_slverr), 64'h8);
      check_eq("t5_m_wait", 64'(m_wait),   64'h7);
      tick();
      set_m(3, 0, '0, '0, '0);
      settle();
      tick();

      // Reset asserted during a waited transfer.
      set_m(0, 1, '0, 32'h500, '0);
      set_s(1, '0, 0);
      settle();
      tick();
      settle();
      tick();
      settle();
      rst = 1'b1;
      #1;
      model_reset();
      check_eq("t6_s_ena",  64'(s_ena),  64'd0);
      check_eq("t6_m_wait", 64'(m_wait), 64'hF);
      check_eq("t6_gvalid", 64'(gvalid), 64'd0);
      for (int i = 0; i < N; i++) set_m(i, 1, '0, 32'h1000 + 32'(i), '0);
      set_s(0, 32'h600D, 0);
      tick();
      rst = 1'b0;

      // Four persistent requesters: round-robin order from master 0.
      for (int k = 0; k < 10; k++) begin
         settle();
         check_eq("t2_gvalid", 64'(gvalid), 64'(k % 2));
         if (k % 2 == 1) check_eq("t2_order", 64'(gid), 64'(seq[k/2]));
         tick();
      end

      // Randomized phase.
      for (int c = 0; c < 800; c++) begin
         if (c % 40 == 0) stuck = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < N; i++) begin
            if (!m_ena[i] || done[i]) begin
               if ($urandom_range(0, 2) != 0)
                  set_m(i, 1, ($urandom_range(0, 1) == 1) ? SW'($urandom) : '0,
                        AW'($urandom), DW'($urandom));
               else
                  set_m(i, 0, '0, '0, '0);
            end
         end
         set_s(stuck ? 1'b1 : ($urandom_range(0, 2) == 0), DW'($urandom),
               $urandom_range(0, 7) == 0);
         settle();
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
